aes_iter: RTL and testbench
===========================

AES_ITER -- requirements
Module: aes_iter

Interface
REQ-001: KEY_BITS, default 128, cipher key length; legal values are 128 and 256, and any other value SHALL stop elaboration with an error.
REQ-002: NR, derived and not overridable, round count: 10 when KEY_BITS=128, 14 when KEY_BITS=256.
REQ-003: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004: nreset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005: in_valid  input  1  plaintext and key are presented.
REQ-006: in_ready  output  1  block can accept a new job.
REQ-007: state  input  128  plaintext; bit 127 is the first FIPS-197 byte.
REQ-008: key  input  KEY_BITS  cipher key; bit KEY_BITS-1 is the first key byte.
REQ-009: out_valid  output  1  ciphertext on out is valid.
REQ-010: out_ready  input  1  consumer accepts the ciphertext.
REQ-011: out  output  128  ciphertext, with the same byte order as state.
REQ-012: busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013: The block SHALL perform AES encryption iteratively, one round per clock, using a 3-state FSM: IDLE, RUN, DONE.
REQ-014: in_ready SHALL be high only in IDLE; busy SHALL equal (FSM != IDLE).
REQ-015: In IDLE, in_valid&&in_ready at edge t SHALL:
- register state^key[KEY_BITS-1 -:128];
- load the key schedule registers;
- set rcon=0x01 and round=1;
- move the FSM to RUN.
REQ-016: In RUN, each edge SHALL apply one round and increment round:
- rounds 1..NR-1: SubBytes, ShiftRows, MixColumns, AddRoundKey;
- round NR: MixColumns omitted.
REQ-017: Round keys SHALL be generated on the fly; no full expanded-key storage is permitted.
- KEY_BITS=128: the next key is derived each round with RotWord/SubWord/rcon, and rcon advances by GF(2^8) xtime (0x80 to 0x1b).
- KEY_BITS=256: two 128-bit halves are held and alternate. Even steps use RotWord/SubWord/rcon; odd steps use SubWord only, with no rcon.
REQ-018: At the edge completing round NR (edge t+NR), out SHALL be loaded, out_valid SHALL go to 1 and the FSM SHALL go to DONE.
- Latency is NR cycles from the acceptance edge: 10 for KEY_BITS=128, 14 for KEY_BITS=256.
REQ-019: In DONE, out and out_valid SHALL hold stable until out_valid&&out_ready; at that edge out_valid drops and the FSM returns to IDLE.
REQ-020: Minimum issue interval SHALL be NR+2 cycles, with no overlap of jobs.
REQ-021: in_valid, state and key SHALL be ignored while in_ready=0; the inputs need not be held after acceptance.
REQ-022: out_ready asserted while out_valid=0 SHALL have no effect.
REQ-023: out SHALL retain its last ciphertext after handshake until the next job completes.

Reset
REQ-024: nreset=0 at any edge SHALL force the following, including mid-RUN or in DONE, discarding the job in flight:
- FSM=IDLE, round=0, rcon=0x01;
- out_valid=0, busy=0, in_ready=1 (in_ready is combinational from IDLE);
- out=0 and the datapath state register=0.
REQ-025: A job offered in the first cycle after nreset rises SHALL be accepted.

Structure
REQ-026: Shared package/header aes_pkg SHALL hold:
- FSM state encodings;
- NR lookup by KEY_BITS;
- initial rcon value (0x01);
- the xtime reduction constant (0x1b).
REQ-027: Sub-module aes_round SHALL implement one combinational round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey) with a final-round input, reusing the team's existing S-box module.
- It is instantiated once.
- A separate 4-S-box instance serves the key schedule.

Verification
REQ-028: KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, state 3243f6a8885a308d313198a2e0370734 -> out 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 10 cycles after acceptance.
REQ-029: KEY_BITS=128 checks:
- key 000102030405060708090a0b0c0d0e0f, state 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a;
- key 0, state 0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
REQ-030: KEY_BITS=256 checks, each with out_valid exactly 14 cycles after acceptance:
- key 000102...1e1f, state 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089;
- key 0, state 0 -> dc95c078a2408989ad48a21492842087.
REQ-031: Backpressure: hold out_ready=0 for 5 cycles after out_valid and toggle in_valid with junk data -> out stable, in_ready=0, and no new job accepted. Then out_ready=1 -> IDLE on the next edge.
REQ-032: Reset mid-RUN at round 5 -> out_valid=0, in_ready=1 and out=0 on the next cycle; a fresh job then produces the correct ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM encoding, round-count lookup and GF(2^8) helpers for the AES core.
package aes_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1b;

    function automatic int nr_for(input int key_bits);
        return key_bits == 256 ? 14 : 10;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? XTIME_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] s, r;
        s = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction
endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES encryption round; final_i drops MixColumns.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         final_i,
    output logic [127:0] state_o
);
    logic [7:0]   sb [16];
    logic [127:0] sr, mc;
    // byte g sits at row g%4, column g/4; ShiftRows pulls from column (c+r)%4
    for (genvar g = 0; g < 16; g++) begin : g_sb
        aes_sbox u_sbox (.a_i(state_i[127-8*g -: 8]), .y_o(sb[g]));
        assign sr[127-8*g -: 8] = sb[4*(((g/4) + (g%4)) % 4) + g%4];
    end
    for (genvar c = 0; c < 4; c++) begin : g_mc
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = sr[127-32*c -: 32];
        assign mc[127-32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end
    assign state_o = (final_i ? sr : mc) ^ rkey_i;
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: AES forward S-box, GF(2^8) inverse followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    logic [7:0] b;
    assign b   = ginv(a_i);
    assign y_o = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_iter.sv
// aes_iter: iterative AES-128/256 encryptor, one round per clock with on-the-fly key expansion.
module aes_iter
    import aes_pkg::*;
#(
    parameter  int KEY_BITS = 128,
    localparam int NR       = nr_for(KEY_BITS)
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        state,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out,
    output logic                busy
);
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_iter: KEY_BITS must be 128 or 256");
    end

    localparam bit IS256 = KEY_BITS == 256;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] st_q, st_d, ka_q, ka_d, kb_q, kb_d, out_q, out_d;
    logic         ov_q, ov_d;
    logic [31:0]  sub, t, w0, w1, w2, w3;
    logic [127:0] key_nx, rkey, rnd_out;
    logic         rot, last;

    // ka holds the older schedule half and kb the newer; for 128-bit keys both track the same key
    for (genvar g = 0; g < 4; g++) begin : g_ks
        aes_sbox u_ksbox (.a_i(kb_q[8*g +: 8]), .y_o(sub[8*g +: 8]));
    end
    assign rot    = !IS256 || round_q[0];
    assign t      = rot ? {sub[23:0], sub[31:24]} ^ {rcon_q, 24'h0} : sub;
    assign w0     = ka_q[127:96] ^ t;
    assign w1     = ka_q[95:64] ^ w0;
    assign w2     = ka_q[63:32] ^ w1;
    assign w3     = ka_q[31:0] ^ w2;
    assign key_nx = {w0, w1, w2, w3};
    assign rkey   = IS256 ? kb_q : key_nx;
    assign last   = round_q == 4'(NR);

    aes_round u_round (.state_i(st_q), .rkey_i(rkey), .final_i(last), .state_o(rnd_out));

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        st_d    = st_q;
        ka_d    = ka_q;
        kb_d    = kb_q;
        out_d   = out_q;
        ov_d    = ov_q;
        if (fsm_q == IDLE && in_valid) begin
            st_d    = state ^ key[KEY_BITS-1 -: 128];
            ka_d    = key[KEY_BITS-1 -: 128];
            kb_d    = key[127:0];
            rcon_d  = RCON_INIT;
            round_d = 4'd1;
            fsm_d   = RUN;
        end else if (fsm_q == RUN) begin
            st_d    = rnd_out;
            ka_d    = IS256 ? kb_q : key_nx;
            kb_d    = key_nx;
            rcon_d  = rot ? xtime(rcon_q) : rcon_q;
            round_d = round_q + 4'd1;
            out_d   = last ? rnd_out : out_q;
            ov_d    = last;
            fsm_d   = last ? DONE : RUN;
        end else if (fsm_q == DONE && out_ready) begin
            ov_d  = 1'b0;
            fsm_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            rcon_q  <= RCON_INIT;
            st_q    <= '0;
            ka_q    <= '0;
            kb_q    <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            st_q    <= st_d;
            ka_q    <= ka_d;
            kb_q    <= kb_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = fsm_q == IDLE;
    assign busy      = fsm_q != IDLE;
    assign out_valid = ov_q;
    assign out       = out_q;
endmodule

// File: tb/tb_aes_iter.sv
// tb_aes_iter: directed FIPS-197 vectors, handshake, backpressure and reset checks for AES-128 and AES-256.
module tb_aes_iter;
    logic         clk = 1'b0, nreset = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sel = 1'b0;
    logic [127:0] pt_in = '0;
    logic [255:0] key_in = '0;
    logic         rdy128, rdy256, ov128, ov256, busy128, busy256;
    logic [127:0] out128, out256;
    logic         in_ready, out_valid, busy;
    logic [127:0] out;
    int           n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    aes_iter #(.KEY_BITS(128)) dut128 (
        .clk(clk), .nreset(nreset), .in_valid(in_valid && !sel), .in_ready(rdy128),
        .state(pt_in), .key(key_in[127:0]), .out_valid(ov128), .out_ready(out_ready),
        .out(out128), .busy(busy128)
    );
    aes_iter #(.KEY_BITS(256)) dut256 (
        .clk(clk), .nreset(nreset), .in_valid(in_valid && sel), .in_ready(rdy256),
        .state(pt_in), .key(key_in), .out_valid(ov256), .out_ready(out_ready),
        .out(out256), .busy(busy256)
    );

    assign in_ready  = sel ? rdy256 : rdy128;
    assign out_valid = sel ? ov256 : ov128;
    assign busy      = sel ? busy256 : busy128;
    assign out       = sel ? out256 : out128;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        pt_in  = {$urandom, $urandom, $urandom, $urandom};
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic start(input logic w, input logic [255:0] k, input logic [127:0] pt);
        sel = w;
        key_in = k;
        pt_in = pt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        junk();
        check("busy_run", 128'(busy), 128'd1);
        check("in_ready_run", 128'(in_ready), 128'd0);
    endtask

    task automatic wait_out(input string tag, input logic [127:0] exp, input int nr);
        int lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'(nr + 1));
        check({tag, "_ct"}, out, exp);
    endtask

    task automatic handshake(input string tag, input logic [127:0] exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 128'(out_valid), 128'd0);
        check({tag, "_idle"}, 128'(in_ready), 128'd1);
        check({tag, "_hold"}, out, exp);
    endtask

    task automatic job(input string tag, input logic w, input logic [255:0] k, input logic [127:0] pt,
                       input logic [127:0] exp);
        start(w, k, pt);
        wait_out(tag, exp, w ? 14 : 10);
        handshake(tag, exp);
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        tick();
        tick();
        check("rst_rdy128", 128'(rdy128), 128'd1);
        check("rst_busy128", 128'(busy128), 128'd0);
        check("rst_ov128", 128'(ov128), 128'd0);
        check("rst_out128", out128, 128'd0);
        check("rst_rdy256", 128'(rdy256), 128'd1);
        check("rst_ov256", 128'(ov256), 128'd0);
        nreset = 1'b1;
        // offered in the very first cycle after reset release
        job("fips128", 1'b0, {128'h0, FIPS_KEY}, FIPS_PT, FIPS_CT);
        job("c1_128", 1'b0, {128'h0, 128'h000102030405060708090a0b0c0d0e0f},
            128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        job("zero128", 1'b0, 256'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        job("c3_256", 1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089);
        job("zero256", 1'b1, 256'h0, 128'h0, 128'hdc95c078a2408989ad48a21492842087);

        start(1'b0, {128'h0, FIPS_KEY}, FIPS_PT);
        wait_out("bp", FIPS_CT, 10);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            junk();
            tick();
            check("bp_out_stable", out, FIPS_CT);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            check("bp_ov_held", 128'(out_valid), 128'd1);
        end
        in_valid = 1'b0;
        handshake("bp", FIPS_CT);
        check("bp_busy_idle", 128'(busy), 128'd0);

        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("idle_ready_noeffect_ov", 128'(out_valid), 128'd0);
        check("idle_ready_noeffect_out", out, FIPS_CT);

        start(1'b0, {128'h0, 128'h000102030405060708090a0b0c0d0e0f}, 128'h00112233445566778899aabbccddeeff);
        repeat (4) tick();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        check("midrst_ov", 128'(out_valid), 128'd0);
        check("midrst_rdy", 128'(in_ready), 128'd1);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_out", out, 128'd0);
        job("after_rst", 1'b0, {128'h0, FIPS_KEY}, FIPS_PT, FIPS_CT);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
